soc_system_key_pio: RTL and testbench

Parametrised Avalon-MM input PIO for pushbuttons and switches on the HPS lightweight bridge. It is the successor to the fixed 4-bit key port. Each input bit passes through a two-flop synchroniser and a per-bit debounce counter. The block captures edges per bit, applies a maskable level interrupt, and exposes everything through a 4-word register map with registered, 1-cycle-latency reads.

---
 rtl/soc_system_key_pio.sv | 107 ++++++++++
 tb/tb_soc_system_key_pio.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_key_pio.sv
// Avalon-MM input PIO for keys/switches: two-flop synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, maskable level interrupt, registered reads.
module soc_system_key_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned   CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s_q, s_d;
  logic [WIDTH-1:0]         deb_q, deb_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         irqmask_q, irqmask_d;
  logic [WIDTH-1:0]         edgecap_q, edgecap_d;
  logic [31:0]              readdata_q, readdata_d;

  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] edge_match;
  logic             wr_en;
  logic             unused_wdata;

  // Bits of writedata above WIDTH are architecturally ignored.
  assign unused_wdata = ^writedata;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    s1_d  = in_port;
    s_d   = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    upd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s_q[i];
        cnt_d[i] = '0;
        upd[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // s_q holds the level being accepted, so it tells the edge direction.
    case (EDGE_TYPE)
      0:       edge_match = s_q;
      1:       edge_match = ~s_q;
      default: edge_match = '1;
    endcase

    wr_en     = chipselect && !write_n;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    // Capture is OR-ed after the clear so a coincident set wins.
    edgecap_d = edgecap_d | (upd & edge_match);

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is
  // reset too, so a count in progress is discarded and never produces a stray update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= RESET_VALUE;
      s_q        <= RESET_VALUE;
      deb_q      <= RESET_VALUE;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s_q        <= s_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_key_pio.sv
// Directed bench for soc_system_key_pio: three instances cover falling, rising and
// any-edge capture; read results flow through an expected-value scoreboard.
module tb_soc_system_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a, in_b;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  soc_system_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  soc_system_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  soc_system_key_pio #(.WIDTH(32), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an address, queue the expected word, compare after the 1-cycle read latency.
  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    address = a;
    sb.push_back(e);
    tick();
    got = sb.pop_front();
    check(got.tag, (got.sel == 0) ? rd_a : (got.sel == 1) ? rd_b : rd_c, got.exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = 4'hF;
    in_b       = 4'hF;
    in_c       = '1;

    // Reset defaults
    idle(3);
    check("rst_hold_readdata", rd_a, 32'h0);
    check("rst_hold_irq", irq_a, 1'b0);
    reset_n = 1'b1;
    idle(2);
    rd(0, 2'd0, 32'hF, "rst_deb");
    rd(0, 2'd1, 32'h0, "rst_addr1");
    rd(0, 2'd2, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_ec");
    check("rst_irq", irq_a, 1'b0);
    idle(8);
    rd(0, 2'd3, 32'h0, "no_cap_after_release");
    rd(2, 2'd0, 32'hFFFF_FFFF, "rst_deb_w32");

    // Debounce accept: deb[0] falls at edge 6, visible on readdata after edge 7
    in_a[0] = 1'b0;
    for (int k = 1; k <= 7; k++) rd(0, 2'd0, (k == 7) ? 32'hE : 32'hF, $sformatf("deb_edge%0d", k));
    rd(0, 2'd3, 32'h1, "accept_ec");
    check("irq_masked", irq_a, 1'b0);
    wr(2'd2, 32'h1);
    check("irq_unmasked", irq_a, 1'b1);
    rd(0, 2'd2, 32'h1, "mask_readback");

    // Glitch reject (3 cycles), then accept (4 cycles)
    in_a[1] = 1'b0;
    idle(3);
    in_a[1] = 1'b1;
    idle(10);
    rd(0, 2'd0, 32'hE, "glitch_deb");
    rd(0, 2'd3, 32'h1, "glitch_ec");
    in_a[1] = 1'b0;
    idle(4);
    in_a[1] = 1'b1;
    idle(12);
    rd(0, 2'd3, 32'h3, "pulse4_ec");
    rd(0, 2'd0, 32'hE, "pulse4_deb_back");

    // W1C of bit 0 only; irq drops right after the write edge
    wr(2'd3, 32'h1);
    check("w1c_irq", irq_a, 1'b0);
    rd(0, 2'd3, 32'h2, "w1c_ec");

    // Set wins: clear of bit 2 lands on the bit-2 update edge (edge 6)
    in_a[2] = 1'b0;
    idle(5);
    wr(2'd3, 32'h4);
    rd(0, 2'd3, 32'h6, "set_wins_ec");
    rd(0, 2'd0, 32'hA, "set_wins_deb");

    // Mid-count reset with c[2]=2 and irq asserted
    wr(2'd2, 32'hF);
    check("pre_reset_irq", irq_a, 1'b1);
    in_a[2] = 1'b1;
    idle(4);
    check("pre_reset_cnt2", {30'b0, dut_a.cnt_q[2]}, 32'd2);
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", rd_a, 32'h0);
    check("midrst_irq", irq_a, 1'b0);
    in_a = 4'hF;
    idle(2);
    reset_n = 1'b1;
    idle(10);
    rd(0, 2'd0, 32'hF, "post_rst_deb");
    rd(0, 2'd1, 32'h0, "post_rst_addr1");
    rd(0, 2'd2, 32'h0, "post_rst_mask");
    rd(0, 2'd3, 32'h0, "post_rst_ec");
    check("post_rst_irq", irq_a, 1'b0);

    // Rising-edge instance: press ignored, release captured
    in_b[0] = 1'b0;
    idle(10);
    rd(1, 2'd0, 32'hE, "rise_press_deb");
    rd(1, 2'd3, 32'h0, "rise_press_ec");
    in_b[0] = 1'b1;
    idle(10);
    rd(1, 2'd3, 32'h1, "rise_release_ec");

    // Any-edge instance, WIDTH=32, bit 31
    in_c[31] = 1'b0;
    idle(6);
    rd(2, 2'd0, 32'h7FFF_FFFF, "any_press_deb");
    rd(2, 2'd3, 32'h8000_0000, "any_press_ec");
    wr(2'd3, 32'h8000_0000);
    rd(2, 2'd3, 32'h0, "any_w1c_ec");
    in_c[31] = 1'b1;
    idle(6);
    rd(2, 2'd3, 32'h8000_0000, "any_release_ec");

    // Mask write coincident with a capture (update at edge 4 for DEBOUNCE_CYCLES=2)
    in_c[0] = 1'b0;
    idle(3);
    check("coincident_irq_before", irq_c, 1'b0);
    wr(2'd2, 32'h1);
    check("coincident_irq_after", irq_c, 1'b1);
    rd(2, 2'd3, 32'h8000_0001, "coincident_ec");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
